instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder side of the main opcode decoder in the multi-cycle core.
- Accepts symbolic instructions (class plus fields) over a valid/ready handshake and assembles 32-bit MIPS words.
- Writes the words sequentially into instruction memory through a 2-entry output buffer.
- Used by test/boot logic to preload programs; opcodes match the decoder exactly, so decode(encode(x)) round-trips.

Parameters:
ADDR_W, 6, instruction-memory word-address width
DEPTH, 64, number of words to load (must be <= 2**ADDR_W)
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: reset write pointer to BASE_ADDR, enter LOAD
finish  input  1  pulse: stop loading (ignored unless in LOAD)
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept this cycle
in_class  input  3  0=R,1=lw,2=sw,3=beq,4=j,5=addi,6/7 illegal
in_rs  input  5  source register
in_rt  input  5  second source / I-type destination
in_rd  input  5  R-type destination
in_fsel  input  3  R funct: 0 add,1 sub,2 and,3 or,4 slt, others illegal
in_imm  input  16  I-type immediate / branch offset
in_target  input  26  jump target
mem_valid  output  1  write request valid
mem_ready  input  1  memory accepts write
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  encoded word
busy  output  1  state is LOAD or DRAIN
done  output  1  1-cycle pulse when DRAIN completes
err  output  1  sticky: illegal class/fsel seen; cleared by start

Behaviour:
- Reset: state IDLE, buffer empty, pointer=BASE_ADDR, in_ready=0, mem_valid=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
- States:
  - IDLE: start -> LOAD.
  - LOAD: finish, or the DEPTH-th accept -> DRAIN.
  - DRAIN: buffer empty (and pad complete if enabled) -> IDLE with done pulse.
- start in any state: flush buffer, pointer=BASE_ADDR, err=0, count=0, go to LOAD. start beats finish when both are asserted.
- in_ready = (state==LOAD) && buffer count<2 && accepted count<DEPTH.
- Accept when in_valid&&in_ready: encode combinationally and push {addr=pointer, word} into the buffer; pointer+1 modulo 2**ADDR_W; count+1.
- Encoding:
  - R: {000000,rs,rt,rd,00000,funct}; funct 100000/100010/100100/100101/101010.
  - lw: {100011,rs,rt,imm}.
  - sw: {101011,rs,rt,imm}.
  - beq: {000100,rs,rt,imm}.
  - j: {000010,target}.
  - addi: {001000,rs,rt,imm}.
- Illegal class or fsel: still accepted, word=32'h0 (NOP), err set next cycle.
- Output: mem_valid = buffer non-empty; head drives mem_addr/mem_wdata registered (no combinational path from in_* to mem_*). Pop on mem_valid&&mem_ready.
- Latency: accept at cycle N gives mem_valid at N+1 if the buffer was empty.
- Push and pop in the same cycle with 2 entries: allowed; count stays 2.
- Backpressure: mem_ready=0 holds mem_addr/mem_wdata stable until popped.
- Reset mid-operation: everything returns to reset values immediately; no partial write is completed.

Optional Feature:
- Macro INSTR_ENC_NOP_PAD_EN.
- Defined: in DRAIN, after real words, the block generates NOP words (32'h0) at successive addresses until count==DEPTH, then done. in_ready=0 while padding; padding obeys mem_ready.
- Undefined: DRAIN only empties the buffer; unwritten addresses are untouched.

Test Plan:
- Reset, then start; send R add rs=1,rt=2,rd=3 -> mem_addr=0, mem_wdata=32'h00221820, one handshake.
- lw rs=0,rt=8,imm=4; sw rs=0,rt=8,imm=8; beq 1,2,imm=FFFF; j target=0x10; addi rs=0,rt=9,imm=5 -> words 8C080004, AC080008, 1022FFFF, 08000010, 20090005 at addr 0..4.
- Hold mem_ready=0 with in_valid=1 -> exactly 2 accepts, then in_ready=0; words stable; release -> in-order drain, no loss or duplication.
- in_class=7 -> NOP written, err=1 until next start; subsequent legal instruction still encoded.
- DEPTH=4, send 4 words -> DRAIN, done pulse after last pop; 5th in_valid is not accepted; with INSTR_ENC_NOP_PAD_EN, finish after 1 word -> addr 1..3 written 0, then done.
- Assert rst_n=0 with 2 buffered words -> mem_valid=0 immediately; after release, state IDLE, err=0.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for instr_encoder_loader.
//
// instr_in_if : symbolic-instruction handshake from the program source into
//               the encoder.
//    master modport = instruction producer (drives fields and in_valid)
//    slave  modport = encoder (drives in_ready)
//
// mem_wr_if   : word-write channel from the encoder into instruction memory.
//    master modport = encoder (drives mem_valid, mem_addr, mem_wdata)
//    slave  modport = memory  (drives mem_ready)
// ---------------------------------------------------------------------------

interface instr_in_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_class;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [2:0]  in_fsel;
   logic [15:0] in_imm;
   logic [25:0] in_target;

   modport master (
      output in_valid, in_class, in_rs, in_rt, in_rd, in_fsel, in_imm, in_target,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_class, in_rs, in_rt, in_rd, in_fsel, in_imm, in_target,
      output in_ready
   );
endinterface

interface mem_wr_if #(
   parameter int ADDR_W = 6
);
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata,
      input  mem_ready
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata,
      output mem_ready
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Turns symbolic instructions (class + register/immediate fields) into 32-bit
// MIPS words using the same opcode/funct values as the core's decoder, and
// writes them to consecutive instruction-memory addresses through a 2-entry
// output buffer. Used by test/boot logic to preload programs.
//
// Ports:
//    clk, rst_n      : clock (rising edge), asynchronous active-low reset
//    start           : pulse, restart loading at BASE_ADDR (wins over finish)
//    finish          : pulse, stop accepting and drain (only acts in LOAD)
//    inBus (slave)   : in_valid/in_ready handshake plus instruction fields
//    memBus (master) : mem_valid/mem_ready write channel, mem_addr, mem_wdata
//    busy            : high while loading or draining
//    done            : one-cycle pulse when draining completes
//    err             : sticky flag for illegal class/fsel, cleared by start
//
// Optional feature, macro INSTR_ENC_NOP_PAD_EN:
//    when defined, draining also writes NOP words (32'h0) to the remaining
//    addresses until DEPTH words have been written in total.
// ---------------------------------------------------------------------------

module instr_encoder_loader #(
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      start,
   input  logic      finish,
   instr_in_if.slave inBus,
   mem_wr_if.master  memBus,
   output logic      busy,
   output logic      done,
   output logic      err
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        bufCnt_q, bufCnt_d;
   logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic [31:0]       word0_q, word0_d, word1_q, word1_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  acceptCnt_q, acceptCnt_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   logic              inReady;
   logic              accept;
   logic              pop;
   logic              push;
   logic              padPush;
   logic              padDone;
   logic [31:0]       pushWord;
   logic [31:0]       encWord;
   logic              encIllegal;
   logic [5:0]        funct;
   logic [1:0]        cntAfterPop;

   // Instruction encoder. Illegal classes and R-type function selects encode
   // as an all-zero NOP and raise encIllegal so the sticky error can be set.
   always_comb begin
      encWord    = 32'h0;
      encIllegal = 1'b0;
      funct      = 6'b000000;
      case (inBus.in_fsel)
         3'd0:    funct = 6'b100000;
         3'd1:    funct = 6'b100010;
         3'd2:    funct = 6'b100100;
         3'd3:    funct = 6'b100101;
         3'd4:    funct = 6'b101010;
         default: funct = 6'b000000;
      endcase
      case (inBus.in_class)
         3'd0: begin
            if (inBus.in_fsel > 3'd4) begin
               encIllegal = 1'b1;
            end else begin
               encWord = {6'b000000, inBus.in_rs, inBus.in_rt, inBus.in_rd, 5'b00000, funct};
            end
         end
         3'd1:    encWord = {6'b100011, inBus.in_rs, inBus.in_rt, inBus.in_imm};
         3'd2:    encWord = {6'b101011, inBus.in_rs, inBus.in_rt, inBus.in_imm};
         3'd3:    encWord = {6'b000100, inBus.in_rs, inBus.in_rt, inBus.in_imm};
         3'd4:    encWord = {6'b000010, inBus.in_target};
         3'd5:    encWord = {6'b001000, inBus.in_rs, inBus.in_rt, inBus.in_imm};
         default: encIllegal = 1'b1;
      endcase
   end

   // Handshake qualifiers. Only LOAD accepts instructions, and only while the
   // buffer has room and the DEPTH quota is not used up. In DRAIN the padding
   // logic (when built in) uses the same buffer slot rules as real words.
   always_comb begin
      inReady = (state_q == LOAD) && (bufCnt_q != 2'd2) &&
                (acceptCnt_q != CNT_W'(DEPTH));
      accept  = inBus.in_valid && inReady;
      pop     = (bufCnt_q != 2'd0) && memBus.mem_ready;
`ifdef INSTR_ENC_NOP_PAD_EN
      padPush = (state_q == DRAIN) && (bufCnt_q != 2'd2) &&
                (acceptCnt_q != CNT_W'(DEPTH));
      padDone = (acceptCnt_q == CNT_W'(DEPTH));
`else
      padPush = 1'b0;
      padDone = 1'b1;
`endif
      push     = accept || padPush;
      pushWord = accept ? encWord : 32'h0;
   end

   // Next-state logic for the whole block. The buffer is a two-slot shift
   // register whose slot 0 is always the head, so the memory outputs come
   // straight from registers. A pop shifts slot 1 down; a push lands in the
   // first slot that is free after that pop. start overrides everything
   // else, including a simultaneous finish or accept.
   always_comb begin
      state_d     = state_q;
      bufCnt_d    = bufCnt_q;
      addr0_d     = addr0_q;
      addr1_d     = addr1_q;
      word0_d     = word0_q;
      word1_d     = word1_q;
      ptr_d       = ptr_q;
      acceptCnt_d = acceptCnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
      cntAfterPop = bufCnt_q - {1'b0, pop};

      if (pop) begin
         addr0_d = addr1_q;
         word0_d = word1_q;
      end
      if (push) begin
         if (cntAfterPop == 2'd0) begin
            addr0_d = ptr_q;
            word0_d = pushWord;
         end else begin
            addr1_d = ptr_q;
            word1_d = pushWord;
         end
         ptr_d       = ptr_q + 1'b1;
         acceptCnt_d = acceptCnt_q + 1'b1;
      end
      bufCnt_d = cntAfterPop + {1'b0, push};

      if (accept && encIllegal) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
         end
         LOAD: begin
            if (finish || (accept && (acceptCnt_q == CNT_W'(DEPTH - 1)))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((bufCnt_q == 2'd0) && padDone) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d     = LOAD;
         bufCnt_d    = 2'd0;
         ptr_d       = ADDR_W'(BASE_ADDR);
         acceptCnt_d = '0;
         err_d       = 1'b0;
      end
   end

   // State registers. Reset clears everything at once, so any buffered words
   // are dropped without being written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bufCnt_q    <= 2'd0;
         addr0_q     <= '0;
         addr1_q     <= '0;
         word0_q     <= 32'h0;
         word1_q     <= 32'h0;
         ptr_q       <= ADDR_W'(BASE_ADDR);
         acceptCnt_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bufCnt_q    <= bufCnt_d;
         addr0_q     <= addr0_d;
         addr1_q     <= addr1_d;
         word0_q     <= word0_d;
         word1_q     <= word1_d;
         ptr_q       <= ptr_d;
         acceptCnt_q <= acceptCnt_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   // Output drive: everything comes from registered state.
   assign inBus.in_ready   = inReady;
   assign memBus.mem_valid = (bufCnt_q != 2'd0);
   assign memBus.mem_addr  = addr0_q;
   assign memBus.mem_wdata = word0_q;
   assign busy             = (state_q != IDLE);
   assign done             = done_q;
   assign err              = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// Testbench for instr_encoder_loader.
// Directed program-load scenarios followed by randomized sessions, checked
// against a reference model: an arithmetic MIPS encoder plus a queue of the
// address/word pairs memory should see, in order.
// ---------------------------------------------------------------------------

module tb_instr_encoder_loader;

   localparam int ADDR_W    = 4;
   localparam int DEPTH     = 8;
   localparam int BASE_ADDR = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic finish = 1'b0;
   logic busy, done, err;

   instr_in_if                     inBus ();
   mem_wr_if #(.ADDR_W(ADDR_W))    memBus ();

   instr_encoder_loader #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .finish(finish),
      .inBus (inBus),
      .memBus(memBus),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       word;
   } entry_t;

   int     testCount = 0;
   int     failCount = 0;
   entry_t expQ[$];
   bit     inLoad   = 1'b0;
   bit     draining = 1'b0;
   bit     padMode  = 1'b0;
   bit     errModel = 1'b0;
   bit     randMem  = 1'b0;
   bit     lastAcc  = 1'b0;
   bit     lastDone = 1'b0;
   int     accepted = 0;

   int opcTab   [6] = '{0, 35, 43, 4, 2, 8};
   int functTab [5] = '{32, 34, 36, 37, 42};

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference encoder: field values weighted by their bit positions.
   function automatic void refEncode(input int cls, input int rs, input int rt,
                                     input int rd, input int fsel, input int imm,
                                     input int target, output logic [31:0] w,
                                     output bit ill);
      longint v;
      v   = 0;
      ill = 1'b0;
      if (cls > 5) begin
         ill = 1'b1;
      end else if (cls == 0) begin
         if (fsel > 4) ill = 1'b1;
         else v = rs * (64'd1 << 21) + rt * (64'd1 << 16) + rd * (64'd1 << 11) + functTab[fsel];
      end else if (cls == 4) begin
         v = opcTab[4] * (64'd1 << 26) + target;
      end else begin
         v = opcTab[cls] * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16) + imm;
      end
      w = v[31:0];
   endfunction

   // Drive one instruction onto the input bus and raise in_valid.
   task automatic applyStimulus(input int cls, input int rs, input int rt, input int rd,
                                input int fsel, input int imm, input int target);
      inBus.in_class  = 3'(cls);
      inBus.in_rs     = 5'(rs);
      inBus.in_rt     = 5'(rt);
      inBus.in_rd     = 5'(rd);
      inBus.in_fsel   = 3'(fsel);
      inBus.in_imm    = 16'(imm);
      inBus.in_target = 26'(target);
      inBus.in_valid  = 1'b1;
   endtask

   task automatic applyRandom();
      int cls, fsel;
      cls  = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      fsel = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      applyStimulus(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    fsel, $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1));
   endtask

   // One clock cycle, called just after a falling edge. Compares outputs
   // with the model, then advances the model by what the next rising edge
   // does, and returns at the following falling edge.
   task automatic tick();
      logic [31:0] w;
      bit          ill, acc, expReady;
      entry_t      e;
      if (randMem) memBus.mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      expReady = inLoad && (expQ.size() < 2) && (accepted < DEPTH);
      checkOutput("in_ready", 32'(inBus.in_ready), 32'(expReady));
      checkOutput("err", 32'(err), 32'(errModel));
      lastDone = done;
      if (done) begin
         checkOutput("busy_at_done", 32'(busy), 32'd0);
         checkOutput("done_while_draining", 32'(draining), 32'd1);
         checkOutput("words_left_at_done", 32'(expQ.size()), 32'd0);
         draining = 1'b0;
         padMode  = 1'b0;
      end else begin
         checkOutput("busy", 32'(busy), 32'(inLoad || draining));
      end
      if (!padMode) checkOutput("mem_valid", 32'(memBus.mem_valid), 32'(expQ.size() != 0));
      if (memBus.mem_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("mem_valid_extra", 32'd1, 32'd0);
         end else begin
            checkOutput("mem_addr", 32'(memBus.mem_addr), 32'(expQ[0].addr));
            checkOutput("mem_wdata", memBus.mem_wdata, expQ[0].word);
            if (memBus.mem_ready) void'(expQ.pop_front());
         end
      end
      acc     = inBus.in_valid && inBus.in_ready && !start;
      lastAcc = acc;
      refEncode(int'(inBus.in_class), int'(inBus.in_rs), int'(inBus.in_rt), int'(inBus.in_rd),
                int'(inBus.in_fsel), int'(inBus.in_imm), int'(inBus.in_target), w, ill);
      if (start) begin
         expQ.delete();
         inLoad   = 1'b1;
         draining = 1'b0;
         padMode  = 1'b0;
         accepted = 0;
         errModel = 1'b0;
      end else begin
         if (acc) begin
            e.addr = ADDR_W'(BASE_ADDR + accepted);
            e.word = w;
            expQ.push_back(e);
            accepted++;
            if (ill) errModel = 1'b1;
         end
         if (inLoad && (finish || accepted == DEPTH)) begin
            inLoad   = 1'b0;
            draining = 1'b1;
`ifdef INSTR_ENC_NOP_PAD_EN
            for (int k = accepted; k < DEPTH; k++) begin
               e.addr = ADDR_W'(BASE_ADDR + k);
               e.word = 32'h0;
               expQ.push_back(e);
               padMode = 1'b1;
            end
`endif
         end
      end
      @(negedge clk);
   endtask

   task automatic waitAccept();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         tick();
         got = lastAcc;
      end
      if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
      inBus.in_valid = 1'b0;
   endtask

   task automatic sendInstr(input int cls, input int rs, input int rt, input int rd,
                            input int fsel, input int imm, input int target);
      applyStimulus(cls, rs, rt, rd, fsel, imm, target);
      waitAccept();
   endtask

   task automatic sendRandom();
      applyRandom();
      waitAccept();
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulseFinish();
      finish = 1'b1;
      tick();
      finish = 1'b0;
   endtask

   task automatic waitDone();
      bit got;
      got = 1'b0;
      inBus.in_valid = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         tick();
         got = lastDone;
      end
      if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset, directed program loads, then random sessions.
   initial begin
      int n;
      inBus.in_valid  = 1'b0;
      inBus.in_class  = 3'd0;
      inBus.in_rs     = 5'd0;
      inBus.in_rt     = 5'd0;
      inBus.in_rd     = 5'd0;
      inBus.in_fsel   = 3'd0;
      inBus.in_imm    = 16'd0;
      inBus.in_target = 26'd0;
      memBus.mem_ready = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_in_ready", 32'(inBus.in_ready), 32'd0);
      checkOutput("rst_mem_valid", 32'(memBus.mem_valid), 32'd0);
      checkOutput("rst_mem_addr", 32'(memBus.mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", memBus.mem_wdata, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("[TB] single R-type add");
      pulseStart();
      sendInstr(0, 1, 2, 3, 0, 0, 0);
      pulseFinish();
      waitDone();

      $display("[TB] one of each I/J class");
      pulseStart();
      sendInstr(1, 0, 8, 0, 0, 16'h0004, 0);
      sendInstr(2, 0, 8, 0, 0, 16'h0008, 0);
      sendInstr(3, 1, 2, 0, 0, 16'hFFFF, 0);
      sendInstr(4, 0, 0, 0, 0, 0, 26'h10);
      sendInstr(5, 0, 9, 0, 0, 16'h0005, 0);
      pulseFinish();
      waitDone();

      $display("[TB] backpressure with buffer full");
      pulseStart();
      memBus.mem_ready = 1'b0;
      applyRandom();
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (lastAcc) begin
            n++;
            applyRandom();
         end
      end
      checkOutput("bp_accept_count", 32'(n), 32'd2);
      memBus.mem_ready = 1'b1;
      waitAccept();
      sendRandom();
      pulseFinish();
      waitDone();

      $display("[TB] illegal class and fsel");
      pulseStart();
      sendInstr(7, 3, 4, 5, 0, 16'h1234, 0);
      sendInstr(0, 1, 2, 3, 6, 0, 0);
      sendInstr(5, 2, 3, 0, 0, 16'h8001, 0);
      sendInstr(6, 0, 0, 0, 0, 0, 0);
      pulseFinish();
      waitDone();
      tick();

      $display("[TB] DEPTH limit with address wrap");
      pulseStart();
      for (int i = 0; i < DEPTH; i++) sendRandom();
      memBus.mem_ready = 1'b0;
      applyRandom();
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (lastAcc) n++;
      end
      checkOutput("accept_past_depth", 32'(n), 32'd0);
      inBus.in_valid = 1'b0;
      memBus.mem_ready = 1'b1;
      waitDone();

      $display("[TB] restart mid-load, start with finish");
      pulseStart();
      memBus.mem_ready = 1'b0;
      sendRandom();
      sendRandom();
      start  = 1'b1;
      finish = 1'b1;
      tick();
      start  = 1'b0;
      finish = 1'b0;
      memBus.mem_ready = 1'b1;
      sendInstr(0, 31, 30, 29, 4, 0, 0);
      tick();
      pulseFinish();
      waitDone();

      $display("[TB] reset with buffered words");
      pulseStart();
      memBus.mem_ready = 1'b0;
      sendInstr(7, 0, 0, 0, 0, 0, 0);
      sendRandom();
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_mem_valid", 32'(memBus.mem_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_err", 32'(err), 32'd0);
      checkOutput("midrst_in_ready", 32'(inBus.in_ready), 32'd0);
      expQ.delete();
      inLoad   = 1'b0;
      draining = 1'b0;
      padMode  = 1'b0;
      errModel = 1'b0;
      accepted = 0;
      @(negedge clk);
      rst_n = 1'b1;
      memBus.mem_ready = 1'b1;
      repeat (3) tick();

      $display("[TB] randomized sessions");
      randMem = 1'b1;
      for (int s = 0; s < 20; s++) begin
         pulseStart();
         n = $urandom_range(0, 10);
         for (int j = 0; j < n && accepted < DEPTH; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            sendRandom();
         end
         if (accepted < DEPTH) pulseFinish();
         waitDone();
      end
      randMem = 1'b0;
      memBus.mem_ready = 1'b1;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
